// File: rtl/data_mem_pkg.sv
// Shared definitions for the byte-addressable data memory: size encodings,
// sweep FSM states and the store byte-enable helper.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Lane mask for an access of the given size starting at byte offset.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select: shifts the registered word down by the byte offset and
// sign- or zero-extends the selected byte/half/word to the full data width.
module mem_load_align
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            word,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [1:0]                   size,
    input  logic                         zero_ext,
    output logic [DATA_W-1:0]            data
);

    logic [DATA_W-1:0] shifted;
    logic              sign;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: sign = shifted[7];
            SZ_HALF: sign = shifted[15];
            SZ_WORD: sign = shifted[31];
            default: sign = shifted[DATA_W-1];
        endcase
        // Fill first, then overlay the selected lane.
        data = (zero_ext || !sign) ? '0 : '1;
        case (size)
            SZ_BYTE: data[7:0]  = shifted[7:0];
            SZ_HALF: data[15:0] = shifted[15:0];
            SZ_WORD: data[31:0] = shifted[31:0];
            default: data       = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_ls.sv
// Byte-addressable load/store data memory with a registered 1-cycle response.
// Define DATA_MEM_INIT_CLEAR_EN to zero the array with a post-reset sweep.
module data_mem_ls
    import data_mem_pkg::*;
#(
    parameter int SIZE   = 4096,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output state_t            fsm_state
);

    localparam int NB    = DATA_W / 8;
    localparam int WORDS = SIZE / NB;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(WORDS);

    // Handshake: a request transfers on any cycle where req_valid && req_ready;
    // exactly one rsp_valid pulse follows on the next cycle, never stalled.

    logic [DATA_W-1:0] mem [WORDS];

    logic [OFF_W-1:0]  offset;
    logic [IDX_W-1:0]  idx;
    logic              misaligned;
    logic              accept;
    logic              store_we;
    logic [7:0]        be_full;
    logic [DATA_W-1:0] wshift;
    logic              clear_we;
    logic [IDX_W-1:0]  clr_idx;
    logic              unused_bits;

    assign offset      = req_addr[OFF_W-1:0];
    assign idx         = req_addr[OFF_W +: IDX_W];
    assign req_ready   = !init_busy;
    assign accept      = req_valid && req_ready && !reset;
    assign be_full     = byte_mask(req_size, 3'(offset));
    assign wshift      = req_wdata << {offset, 3'b000};
    assign store_we    = accept && req_write && !misaligned;
    assign unused_bits = ^{req_addr, be_full};

    always_comb begin
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = (DATA_W == 32) || (|req_addr[2:0]);
        endcase
    end

`ifdef DATA_MEM_INIT_CLEAR_EN
    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        init_busy  = 1'b0;
        clear_we   = 1'b0;
        case (state)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clear_we  = 1'b1;
                if (clr_cnt == IDX_W'(WORDS - 1)) state_next = ST_READY;
            end
            default: ;
        endcase
    end

    assign clr_idx   = clr_cnt;
    assign fsm_state = state;
`else
    assign init_busy = 1'b0;
    assign clear_we  = 1'b0;
    assign clr_idx   = '0;
    assign fsm_state = ST_READY;
`endif

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_idx] <= '0;
        end else if (store_we) begin
            for (int b = 0; b < NB; b++) begin
                if (be_full[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

    // Read-side registers only move on an accepted request, so the
    // extended data (and hence rsp_rdata) holds between responses.
    logic [DATA_W-1:0] rd_word;
    logic [OFF_W-1:0]  rd_off;
    logic [1:0]        rd_size;
    logic              rd_zext;
    logic              rd_zero;
    logic [DATA_W-1:0] aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid      <= 1'b0;
            rsp_misaligned <= 1'b0;
            rd_word        <= '0;
            rd_off         <= '0;
            rd_size        <= SZ_BYTE;
            rd_zext        <= 1'b1;
            rd_zero        <= 1'b1;
        end else begin
            rsp_valid      <= accept;
            rsp_misaligned <= accept && misaligned;
            if (accept) begin
                rd_word <= mem[idx];
                rd_off  <= offset;
                rd_size <= req_size;
                rd_zext <= req_unsigned;
                rd_zero <= req_write || misaligned;
            end
        end
    end

    mem_load_align #(.DATA_W(DATA_W)) u_load_align (
        .word     (rd_word),
        .offset   (rd_off),
        .size     (rd_size),
        .zero_ext (rd_zext),
        .data     (aligned)
    );

    assign rsp_rdata = rd_zero ? '0 : aligned;

endmodule

// File: doc/data_mem_ls.md
Name: data_mem_ls

Overview:
- Parametrised successor to the CPU's word-only data memory.
- Supports byte, half, word and (for 64-bit builds) double accesses: per-byte write enables, sign/zero-extended loads, misalignment detection.
- Uses a valid/ready request with a registered 1-cycle response, plus a post-reset clear sweep.
- Sits between the CPU's memory stage and the register-file writeback.

Parameters:
- SIZE, 4096, memory capacity in bytes; power of two, multiple of DATA_W/8.
- DATA_W, 32, data path width; legal values 32 or 64.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the clear sweep runs.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  request accepted when req_valid && req_ready; equals !init_busy.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (DATA_W=64 only).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data, right-justified (low bytes used).
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and faults.
- rsp_misaligned  out  1  qualifies rsp_valid; access was misaligned or illegal.

Behaviour:
- Storage: SIZE/(DATA_W/8) words. Word index = req_addr >> log2(DATA_W/8); bits above the index are ignored, so addresses wrap modulo SIZE.
- Reset (in any state): rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, init_busy=1. FSM enters CLEAR, sweep counter=0, any in-flight response is dropped.
- CLEAR state:
  - Writes zero to word[counter] each cycle and increments the counter.
  - After the last word is written, moves to READY next cycle; init_busy falls the same edge.
  - Clear takes exactly SIZE/(DATA_W/8) cycles.
  - req_valid is ignored, with no response generated.
- READY state: one request per cycle, no backpressure.
- Alignment rules:
  - half needs addr[0]=0.
  - word needs addr[1:0]=0.
  - double needs addr[2:0]=0.
  - size 11 with DATA_W=32 is illegal.
- Store accepted at cycle N:
  - If aligned, only the addressed bytes are written at the N edge, using a byte-enable mask shifted by the address offset.
  - rsp_valid=1 at N+1 with rsp_rdata=0 and rsp_misaligned=0.
- Load accepted at cycle N:
  - Word read is registered at N.
  - At N+1: rsp_valid=1, rsp_rdata = selected lane shifted down and then extended to DATA_W.
- Misaligned or illegal request: no write. At N+1, rsp_valid=1, rsp_misaligned=1, rsp_rdata=0.
- Store at N followed by a load of the same address at N+1: the load returns the new data (write completes before the read). No bypass path is needed.
- Cycle after a response with no new request: rsp_valid=0, while rsp_rdata holds its last value.

Optional Feature:
- Macro: DATA_MEM_INIT_CLEAR_EN.
- Defined: CLEAR sweep as above.
- Undefined: FSM and counter removed; init_busy tied 0; req_ready=1 from the cycle after reset; memory contents undefined until written. Output reset values are unchanged.

Decomposition:
- Package data_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE;
  - FSM state typedef (ST_CLEAR, ST_READY);
  - function returning the byte-enable mask for size/offset.
- One sub-module, mem_load_align: combinational lane select plus sign/zero extension, taking the registered word, registered offset, size and unsigned flag.
- The top level holds the array, FSM, counter and response registers.

Test Plan:
- Reset, then hold req_valid=1: init_busy=1 for exactly 1024 cycles (SIZE=4096, DATA_W=32) with no rsp_valid. Then init_busy=0, and a load of 0x0FFC returns 0x00000000.
- Store word 0xDEADBEEF at 0x10, then load byte signed at 0x11 → rsp_rdata=0xFFFFFFBE. Load half unsigned at 0x12 → 0x0000DEAD.
- Store byte 0x7F at 0x13 over 0xDEADBEEF, then load word at 0x10 → 0x7FADBEEF, confirming only one lane changed.
- Store word at 0x22 → rsp_misaligned=1, rsp_rdata=0. A following load word at 0x20 returns the prior contents unchanged. size=11 with DATA_W=32 → rsp_misaligned=1.
- Store 0x12345678 at 0x1000 (wraps to 0x0), then load word at 0x0 → 0x12345678. Back-to-back store/load to the same address returns the new data at N+2.
- Assert reset mid-operation, with a load accepted the previous cycle → no rsp_valid follows. CLEAR restarts from word 0, and all previously written words read 0 afterwards.
